// File: rtl/bit_serial_adder_pkg.sv
// rtl/bit_serial_adder_pkg.sv - shared FSM encodings and sizing helper for the bit-serial adder
package bit_serial_adder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Bit counter must address W positions but never collapse to zero width.
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/full_adder_cell.sv
// rtl/full_adder_cell.sv - full adder composed of two half adders and an OR of their carries
module full_adder_cell (
    output logic s,
    output logic co,
    input  logic x,
    input  logic y,
    input  logic ci
);

    logic s0;
    logic c0;
    logic c1;

    half_adder u_ha0 (.s(s0), .c(c0), .x(x),  .y(y));
    half_adder u_ha1 (.s(s),  .c(c1), .x(s0), .y(ci));

    assign co = c0 | c1;

endmodule

// File: rtl/half_adder.sv
// rtl/half_adder.sv - single-bit half adder
module half_adder (
    output logic s,
    output logic c,
    input  logic x,
    input  logic y
);

    assign s = x ^ y;
    assign c = x & y;

endmodule

// File: rtl/bit_serial_adder.sv
// rtl/bit_serial_adder.sv - W-bit adder that resolves one bit per clock, LSB first, over valid/ready
module bit_serial_adder
    import bit_serial_adder_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] sum,
    output logic         cout
);

    localparam int CW = cnt_width(W);

    state_t        state;
    state_t        state_nxt;
    logic [W-1:0]  a_sr;
    logic [W-1:0]  b_sr;
    logic [W-1:0]  sum_sr;
    logic [W-1:0]  sum_shift;
    logic [W-1:0]  sum_q;
    logic          carry;
    logic          cout_q;
    logic [CW-1:0] count;
    logic          fa_s;
    logic          fa_co;
    logic          last_bit;

    full_adder_cell u_fa (
        .s  (fa_s),
        .co (fa_co),
        .x  (a_sr[0]),
        .y  (b_sr[0]),
        .ci (carry)
    );

    assign last_bit  = (state == ST_RUN) && (count == CW'(W - 1));
    assign sum_shift = (sum_sr >> 1) | (W'(fa_s) << (W - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (in_valid)  state_nxt = ST_RUN;
            ST_RUN:  if (last_bit)  state_nxt = ST_DONE;
            ST_DONE: if (out_ready) state_nxt = ST_IDLE;
            default:                state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == ST_IDLE);
        out_valid = (state == ST_DONE);
    end

    // Result registers are separate from sum_sr so the presented sum stays put
    // through the next operation's RUN phase.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr   <= '0;
            b_sr   <= '0;
            sum_sr <= '0;
            carry  <= 1'b0;
            count  <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_sr   <= a;
                        b_sr   <= b;
                        sum_sr <= '0;
                        carry  <= cin;
                        count  <= '0;
                    end
                end
                ST_RUN: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    sum_sr <= sum_shift;
                    carry  <= fa_co;
                    count  <= count + 1'b1;
                    if (last_bit) begin
                        sum_q  <= sum_shift;
                        cout_q <= fa_co;
                    end
                end
                default: ;
            endcase
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_bit_serial_adder.sv
// tb/tb_bit_serial_adder.sv - directed and randomized checks of bit_serial_adder at W=8 and W=1
module tb_bit_serial_adder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic       in_valid8 = 1'b0, in_ready8, out_valid8, out_ready8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0, sum8;
    logic       cin8 = 1'b0, cout8;

    logic       in_valid1 = 1'b0, in_ready1, out_valid1, out_ready1 = 1'b0;
    logic [0:0] a1 = '0, b1 = '0, sum1;
    logic       cin1 = 1'b0, cout1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bit_serial_adder #(.W(8)) dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .cin(cin8),
        .out_valid(out_valid8), .out_ready(out_ready8),
        .sum(sum8), .cout(cout8)
    );

    bit_serial_adder #(.W(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid1), .in_ready(in_ready1),
        .a(a1), .b(b1), .cin(cin1),
        .out_valid(out_valid1), .out_ready(out_ready1),
        .sum(sum1), .cout(cout1)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            checks++;
            assert (!((in_ready8 & out_valid8) | (in_ready1 & out_valid1))) else begin
                errors++;
                $error("FAIL handshake_overlap got %0b%0b exp 00",
                       in_ready8 & out_valid8, in_ready1 & out_valid1);
            end
        end
    end

    task automatic start8(input logic [7:0] x, input logic [7:0] y, input logic c);
        int k;
        k = 0;
        while (!in_ready8 && k < 50) begin
            @(posedge clk); #1; k++;
        end
        if (k >= 50) chk("start8_timeout", 32'(k), 32'(0));
        a8 = x; b8 = y; cin8 = c; in_valid8 = 1'b1;
        @(posedge clk); #1;
        in_valid8 = 1'b0;
    endtask

    task automatic wait_done8(output int lat);
        lat = 1;
        while (!out_valid8 && lat < 40) begin
            @(posedge clk); #1; lat++;
        end
    endtask

    task automatic handoff8();
        out_ready8 = 1'b1;
        @(posedge clk); #1;
        out_ready8 = 1'b0;
    endtask

    task automatic op1(input logic x, input logic y, input logic c, output int lat);
        int k;
        k = 0;
        while (!in_ready1 && k < 50) begin
            @(posedge clk); #1; k++;
        end
        a1 = x; b1 = y; cin1 = c; in_valid1 = 1'b1;
        @(posedge clk); #1;
        in_valid1 = 1'b0;
        lat = 1;
        while (!out_valid1 && lat < 40) begin
            @(posedge clk); #1; lat++;
        end
    endtask

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       c;
        logic [7:0] s;
        logic       co;
    } vec_t;

    vec_t vecs[4] = '{
        '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0},
        '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1},
        '{8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1},
        '{8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0}
    };

    initial begin
        int lat;
        logic [8:0] exp9;
        logic [7:0] rx, ry;
        logic       rc;
        logic [1:0] exp2;

        #23;
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready",  32'(in_ready8),  32'(1));
        chk("rst_out_valid", 32'(out_valid8), 32'(0));
        chk("rst_sum",       32'(sum8),       32'(0));
        chk("rst_cout",      32'(cout8),      32'(0));

        foreach (vecs[i]) begin
            start8(vecs[i].a, vecs[i].b, vecs[i].c);
            wait_done8(lat);
            chk($sformatf("lat_%0d", i),  32'(lat),   32'(9));
            chk($sformatf("sum_%0d", i),  32'(sum8),  32'(vecs[i].s));
            chk($sformatf("cout_%0d", i), 32'(cout8), 32'(vecs[i].co));
            handoff8();
            chk($sformatf("post_valid_%0d", i), 32'(out_valid8), 32'(0));
            chk($sformatf("post_ready_%0d", i), 32'(in_ready8),  32'(1));
            chk($sformatf("retain_%0d", i),     32'(sum8),       32'(vecs[i].s));
        end

        // Backpressure with stray in_valid pulses during RUN and DONE.
        start8(8'h12, 8'h34, 1'b0);
        a8 = 8'hEE; b8 = 8'hEE; cin8 = 1'b1;
        in_valid8 = 1'b1;
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        @(posedge clk); #1;
        in_valid8 = 1'b1;
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        wait_done8(lat);
        chk("bp_reached_done", 32'(out_valid8), 32'(1));
        in_valid8 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk($sformatf("bp_valid_%0d", i), 32'(out_valid8), 32'(1));
            chk($sformatf("bp_sum_%0d", i),   32'(sum8),       32'(8'h46));
            chk($sformatf("bp_cout_%0d", i),  32'(cout8),      32'(0));
            chk($sformatf("bp_ready_%0d", i), 32'(in_ready8),  32'(0));
        end
        in_valid8 = 1'b0;
        handoff8();
        chk("bp_release", 32'(out_valid8), 32'(0));

        // Asynchronous reset in the middle of RUN (count == 4).
        start8(8'h77, 8'h11, 1'b0);
        repeat (4) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #2;
        chk("midrst_valid", 32'(out_valid8), 32'(0));
        chk("midrst_sum",   32'(sum8),       32'(0));
        chk("midrst_cout",  32'(cout8),      32'(0));
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("midrst_ready", 32'(in_ready8), 32'(1));
        start8(8'h10, 8'h20, 1'b0);
        wait_done8(lat);
        chk("after_rst_lat",  32'(lat),   32'(9));
        chk("after_rst_sum",  32'(sum8),  32'(8'h30));
        chk("after_rst_cout", 32'(cout8), 32'(0));
        handoff8();

        for (int i = 0; i < 200; i++) begin
            rx = 8'($urandom);
            ry = 8'($urandom);
            rc = 1'($urandom);
            exp9 = {1'b0, rx} + {1'b0, ry} + {8'b0, rc};
            start8(rx, ry, rc);
            wait_done8(lat);
            chk($sformatf("rnd8_%0d", i), 32'({cout8, sum8}), 32'(exp9));
            handoff8();
        end

        for (int i = 0; i < 100; i++) begin
            rx = 8'($urandom_range(0, 1));
            ry = 8'($urandom_range(0, 1));
            rc = 1'($urandom);
            exp2 = 2'(rx[0]) + 2'(ry[0]) + 2'(rc);
            op1(rx[0], ry[0], rc, lat);
            if (i == 0) chk("w1_lat", 32'(lat), 32'(2));
            chk($sformatf("rnd1_%0d", i), 32'({cout1, sum1}), 32'(exp2));
            out_ready1 = 1'b1;
            @(posedge clk); #1;
            out_ready1 = 1'b0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
